// File: rtl/sys_ctrl_gen_if.sv
// rtl/sys_ctrl_gen_if.sv - bus bundle between sys_ctrl_gen and the UART, register file and ALU
interface sys_ctrl_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    OUT_VALID;
  logic [DATA_WIDTH-1:0]   RdData;
  logic                    RdData_Valid;
  logic                    Busy;
  logic [FUN_WIDTH-1:0]    ALU_FUN;
  logic                    ALU_EN;
  logic                    CLK_EN;
  logic                    WrEn;
  logic                    RdEn;
  logic [ADDR_WIDTH-1:0]   Address;
  logic [DATA_WIDTH-1:0]   WrData;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;
  logic                    clk_div_en;
  logic                    cmd_err;
  logic                    overrun;

  modport master (
    input  RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_VALID, RdData, RdData_Valid, Busy,
    output ALU_FUN, ALU_EN, CLK_EN, WrEn, RdEn, Address, WrData,
           TX_P_DATA, TX_D_VLD, clk_div_en, cmd_err, overrun
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_VALID, RdData, RdData_Valid, Busy,
    input  ALU_FUN, ALU_EN, CLK_EN, WrEn, RdEn, Address, WrData,
           TX_P_DATA, TX_D_VLD, clk_div_en, cmd_err, overrun
  );
endinterface

// File: rtl/sys_ctrl_gen.sv
// rtl/sys_ctrl_gen.sv - command decoder, response FIFO and UART TX drain for the system controller
module sys_ctrl_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int RESP_DEPTH = 8,
  parameter int OPA_ADDR   = 0,
  parameter int OPB_ADDR   = 1
) (
  input logic            CLK,
  input logic            RST,
  sys_ctrl_gen_if.master bus
);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(RESP_DEPTH);
  localparam logic [PW:0] ONE_C   = (PW+1)'(1);
  localparam logic [PW:0] TWO_C   = (PW+1)'(2);

  typedef enum logic [3:0] {
    IDLE, W_ADDR, W_DATA, WR, R_ADDR, R_ISSUE, R_WAIT, OPA,
    WR_A, OPB, WR_B, FUN, ALU_ISSUE, ALU_WAIT, B_ADDR, B_CNT
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [FUN_WIDTH-1:0]  fun_q, fun_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic wren_q, wren_d, rden_q, rden_d, aluen_q, aluen_d;
  logic clken_q, clken_d, cmderr_q, cmderr_d, ovr_q, ovr_d;
  logic clk_div_en_q;

  // ALU high byte waits one cycle behind the low byte
  logic [DATA_WIDTH-1:0] hi_q;
  logic                  hi_pend_q;
  logic                  fsm_push, alu_done;
  logic [DATA_WIDTH-1:0] fsm_push_data;
  logic [7:0]            opcode;

  logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [PW:0]           count_q, free_w;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  hold_q, busy_seen_q, tx_vld_q;
  logic [DATA_WIDTH-1:0] tx_data_q;

  assign opcode    = bus.RX_P_DATA[7:0];
  // a pending high byte reserves its slot so issue states never overfill
  assign free_w    = DEPTH_C - count_q - {{PW{1'b0}}, hi_pend_q};
  assign push      = fsm_push | hi_pend_q;
  assign push_data = hi_pend_q ? hi_q : fsm_push_data;
  assign pop       = (count_q != '0) && !bus.Busy && !hold_q;

  // next-state and registered-output decode
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    fun_d         = fun_q;
    cnt_d         = cnt_q;
    wren_d        = 1'b0;
    rden_d        = 1'b0;
    aluen_d       = 1'b0;
    clken_d       = clken_q;
    cmderr_d      = 1'b0;
    ovr_d         = 1'b0;
    fsm_push      = 1'b0;
    fsm_push_data = bus.RdData;
    alu_done      = 1'b0;
    case (state_q)
      IDLE: if (bus.RX_D_VLD) begin
        case (opcode)
          8'hAA:   state_d = W_ADDR;
          8'hBB:   state_d = R_ADDR;
          8'hCC:   state_d = OPA;
          8'hDD:   state_d = FUN;
          8'hEE:   state_d = B_ADDR;
          default: cmderr_d = 1'b1;
        endcase
      end
      W_ADDR: if (bus.RX_D_VLD) begin
        addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
        state_d = W_DATA;
      end
      W_DATA: if (bus.RX_D_VLD) begin
        wdata_d = bus.RX_P_DATA;
        wren_d  = 1'b1;
        state_d = WR;
      end
      WR: state_d = IDLE;
      R_ADDR: if (bus.RX_D_VLD) begin
        addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
        cnt_d   = DATA_WIDTH'(1);
        state_d = R_ISSUE;
      end
      R_ISSUE: if (free_w >= ONE_C) begin
        rden_d  = 1'b1;
        state_d = R_WAIT;
      end
      R_WAIT: if (bus.RdData_Valid) begin
        fsm_push = 1'b1;
        if (cnt_q > DATA_WIDTH'(1)) begin
          cnt_d   = cnt_q - DATA_WIDTH'(1);
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = R_ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      OPA: if (bus.RX_D_VLD) begin
        addr_d  = ADDR_WIDTH'(OPA_ADDR);
        wdata_d = bus.RX_P_DATA;
        wren_d  = 1'b1;
        state_d = WR_A;
      end
      WR_A: state_d = OPB;
      OPB: if (bus.RX_D_VLD) begin
        addr_d  = ADDR_WIDTH'(OPB_ADDR);
        wdata_d = bus.RX_P_DATA;
        wren_d  = 1'b1;
        state_d = WR_B;
      end
      WR_B: state_d = FUN;
      FUN: if (bus.RX_D_VLD) begin
        fun_d   = bus.RX_P_DATA[FUN_WIDTH-1:0];
        clken_d = 1'b1;
        state_d = ALU_ISSUE;
      end
      ALU_ISSUE: if (free_w >= TWO_C) begin
        aluen_d = 1'b1;
        state_d = ALU_WAIT;
      end
      ALU_WAIT: if (bus.OUT_VALID) begin
        fsm_push      = 1'b1;
        fsm_push_data = bus.ALU_OUT[DATA_WIDTH-1:0];
        alu_done      = 1'b1;
        clken_d       = 1'b0;
        state_d       = IDLE;
      end
      B_ADDR: if (bus.RX_D_VLD) begin
        addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
        state_d = B_CNT;
      end
      B_CNT: if (bus.RX_D_VLD) begin
        cnt_d   = (bus.RX_P_DATA == '0) ? DATA_WIDTH'(1) : bus.RX_P_DATA;
        state_d = R_ISSUE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.RX_D_VLD && (state_q inside {WR, R_ISSUE, R_WAIT, WR_A, WR_B, ALU_ISSUE, ALU_WAIT}))
      ovr_d = 1'b1;
  end

  // FSM state and command-side output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      fun_q        <= '0;
      cnt_q        <= '0;
      wren_q       <= 1'b0;
      rden_q       <= 1'b0;
      aluen_q      <= 1'b0;
      clken_q      <= 1'b0;
      cmderr_q     <= 1'b0;
      ovr_q        <= 1'b0;
      clk_div_en_q <= 1'b0;
      hi_q         <= '0;
      hi_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      fun_q        <= fun_d;
      cnt_q        <= cnt_d;
      wren_q       <= wren_d;
      rden_q       <= rden_d;
      aluen_q      <= aluen_d;
      clken_q      <= clken_d;
      cmderr_q     <= cmderr_d;
      ovr_q        <= ovr_d;
      clk_div_en_q <= 1'b1;
      hi_pend_q    <= alu_done;
      if (alu_done) hi_q <= bus.ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  // response FIFO storage, no reset needed since pointers gate reads
  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

  // FIFO pointers and TX drain with busy-high-then-low hold
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      hold_q      <= 1'b0;
      busy_seen_q <= 1'b0;
      tx_vld_q    <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop) begin
        rptr_q    <= rptr_q + PW'(1);
        tx_data_q <= mem_q[rptr_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + ONE_C;
        2'b01:   count_q <= count_q - ONE_C;
        default: count_q <= count_q;
      endcase
      tx_vld_q <= pop;
      if (pop) begin
        hold_q      <= 1'b1;
        busy_seen_q <= 1'b0;
      end else if (hold_q) begin
        if (bus.Busy) begin
          busy_seen_q <= 1'b1;
        end else if (busy_seen_q) begin
          hold_q      <= 1'b0;
          busy_seen_q <= 1'b0;
        end
      end
    end
  end

  assign bus.ALU_FUN    = fun_q;
  assign bus.ALU_EN     = aluen_q;
  assign bus.CLK_EN     = clken_q;
  assign bus.WrEn       = wren_q;
  assign bus.RdEn       = rden_q;
  assign bus.Address    = addr_q;
  assign bus.WrData     = wdata_q;
  assign bus.TX_P_DATA  = tx_data_q;
  assign bus.TX_D_VLD   = tx_vld_q;
  assign bus.clk_div_en = clk_div_en_q;
  assign bus.cmd_err    = cmderr_q;
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_sys_ctrl_gen.sv
// tb/tb_sys_ctrl_gen.sv - randomized self-checking bench for sys_ctrl_gen
module tb_sys_ctrl_gen;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;
  localparam int DEPTH = 8;
  localparam int OW = FW + 4 + AW + 2*DW + 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  sys_ctrl_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) bus ();

  sys_ctrl_gen #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW),
    .RESP_DEPTH(DEPTH), .OPA_ADDR(0), .OPB_ADDR(1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int vecs = 0;
  int errs = 0;

  // environment: register file, ALU and UART TX responders
  logic [DW-1:0] regs [2**AW];
  int  rd_delay = 1;
  int  alu_delay = 3;
  bit  busy_hold = 1'b0;
  int  rd_cd = 0, alu_cd = 0, busy_cd = 0;
  logic [AW-1:0] rd_a;
  logic [DW-1:0] tx_q[$];
  logic [AW-1:0] wr_a_q[$];
  logic [DW-1:0] wr_d_q[$];
  logic [AW-1:0] rd_a_q[$];
  int  n_aluen = 0, n_cmderr = 0, n_ovr = 0, clken_bad = 0;

  // specification-level model of register contents
  logic [DW-1:0] mdl_regs [2**AW];

  function automatic logic [2*DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [FW-1:0] f);
    case (f)
      FW'(0):  return (2*DW)'(a) + (2*DW)'(b);
      FW'(1):  return (2*DW)'(a) - (2*DW)'(b);
      FW'(2):  return (2*DW)'(a) * (2*DW)'(b);
      FW'(3):  return (2*DW)'(a & b);
      FW'(4):  return (2*DW)'(a | b);
      default: return {a, b};
    endcase
  endfunction

  function automatic logic [OW-1:0] all_outs();
    return {bus.ALU_FUN, bus.ALU_EN, bus.CLK_EN, bus.WrEn, bus.RdEn, bus.Address, bus.WrData,
            bus.TX_P_DATA, bus.TX_D_VLD, bus.clk_div_en, bus.cmd_err, bus.overrun};
  endfunction

  initial begin
    for (int i = 0; i < 2**AW; i++) regs[i] = DW'(i * 37 + 11);
    bus.RdData = '0; bus.RdData_Valid = 1'b0; bus.ALU_OUT = '0; bus.OUT_VALID = 1'b0; bus.Busy = 1'b0;
    forever begin
      @(negedge CLK);
      bus.RdData_Valid = 1'b0;
      bus.OUT_VALID = 1'b0;
      if (RST) begin
        rd_cd = 0; alu_cd = 0; busy_cd = 0;
      end else begin
        if (bus.WrEn) begin
          regs[bus.Address] = bus.WrData;
          wr_a_q.push_back(bus.Address);
          wr_d_q.push_back(bus.WrData);
        end
        if (rd_cd > 0) begin
          rd_cd--;
          if (rd_cd == 0) begin bus.RdData = regs[rd_a]; bus.RdData_Valid = 1'b1; end
        end
        if (bus.RdEn) begin rd_a_q.push_back(bus.Address); rd_a = bus.Address; rd_cd = rd_delay; end
        if (alu_cd > 0) begin
          if (bus.CLK_EN !== 1'b1) clken_bad++;
          alu_cd--;
          if (alu_cd == 0) begin bus.ALU_OUT = alu_f(regs[0], regs[1], bus.ALU_FUN); bus.OUT_VALID = 1'b1; end
        end
        if (bus.ALU_EN) begin
          n_aluen++;
          if (bus.CLK_EN !== 1'b1) clken_bad++;
          alu_cd = alu_delay;
        end
        if (busy_cd > 0) busy_cd--;
        if (bus.TX_D_VLD) begin tx_q.push_back(bus.TX_P_DATA); busy_cd = 3; end
        if (bus.cmd_err) n_cmderr++;
        if (bus.overrun) n_ovr++;
      end
      bus.Busy = busy_hold || (busy_cd > 0);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send(input logic [DW-1:0] b);
    @(negedge CLK);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD = 1'b1;
    @(negedge CLK);
    bus.RX_D_VLD = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int b = 0;
    while (tx_q.size() < n && b < 400) begin @(negedge CLK); b++; end
  endtask

  task automatic test_reset();
    wait_cycles(3);
    vecs++; if (all_outs() !== '0) begin errs++; $display("FAIL reset_outs: got %h expected 0", all_outs()); end
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK);
    vecs++; if (bus.clk_div_en !== 1'b1) begin errs++; $display("FAIL clk_div_en: got %b expected 1", bus.clk_div_en); end
    vecs++; if (bus.TX_D_VLD !== 1'b0 || bus.WrEn !== 1'b0) begin errs++; $display("FAIL post_reset_idle: tx %b wr %b expected 0", bus.TX_D_VLD, bus.WrEn); end
  endtask

  task automatic test_write();
    logic [AW-1:0] a; logic [DW-1:0] d; int wb, tb;
    for (int k = 0; k < 5; k++) begin
      a = (k == 0) ? AW'(5) : AW'($urandom_range(0, 2**AW-1));
      d = (k == 0) ? DW'(8'h3C) : DW'($urandom);
      if (k == 4) a = AW'(5);
      if (k == 4) d = DW'(8'h3C);
      wb = wr_a_q.size(); tb = tx_q.size();
      send(8'hAA); send(DW'(a)); send(d);
      wait_cycles(4);
      mdl_regs[a] = d;
      vecs++; if (wr_a_q.size() != wb + 1) begin errs++; $display("FAIL write_pulses: got %0d expected 1", wr_a_q.size() - wb); end
      vecs++; if (wr_a_q[wb] !== a) begin errs++; $display("FAIL write_addr: got %h expected %h", wr_a_q[wb], a); end
      vecs++; if (wr_d_q[wb] !== d) begin errs++; $display("FAIL write_data: got %h expected %h", wr_d_q[wb], d); end
      vecs++; if (tx_q.size() != tb) begin errs++; $display("FAIL write_no_tx: got %0d frames expected 0", tx_q.size() - tb); end
    end
  endtask

  task automatic test_read();
    logic [AW-1:0] a; int base;
    for (int k = 0; k < 5; k++) begin
      a = (k == 0) ? AW'(5) : AW'($urandom_range(0, 2**AW-1));
      base = tx_q.size();
      send(8'hBB); send(DW'(a));
      wait_tx(base + 1); wait_cycles(8);
      vecs++; if (tx_q.size() != base + 1) begin errs++; $display("FAIL read_count: got %0d expected 1", tx_q.size() - base); end
      vecs++; if (tx_q[base] !== mdl_regs[a]) begin errs++; $display("FAIL read_data: got %h expected %h", tx_q[base], mdl_regs[a]); end
    end
  endtask

  task automatic test_alu();
    logic [DW-1:0] a, b; logic [FW-1:0] f; logic [2*DW-1:0] exp; bit use_cc; int base, wb, ab, cb;
    for (int k = 0; k < 6; k++) begin
      a = (k == 0) ? DW'(8'h12) : DW'($urandom);
      b = (k == 0) ? DW'(8'h34) : DW'($urandom);
      f = (k == 0) ? FW'(0) : FW'($urandom_range(0, 5));
      use_cc = (k == 0) || ($urandom_range(0, 1) == 1);
      alu_delay = (k == 0) ? 3 : int'($urandom_range(1, 6));
      base = tx_q.size(); wb = wr_a_q.size(); ab = n_aluen; cb = clken_bad;
      if (use_cc) begin
        send(8'hCC); send(a); send(b); send(DW'(f));
        mdl_regs[0] = a; mdl_regs[1] = b;
      end else begin
        send(8'hDD); send(DW'(f));
      end
      exp = alu_f(mdl_regs[0], mdl_regs[1], f);
      wait_tx(base + 2); wait_cycles(8);
      if (use_cc) begin
        vecs++; if (wr_a_q.size() != wb + 2) begin errs++; $display("FAIL alu_wr_count: got %0d expected 2", wr_a_q.size() - wb); end
        vecs++; if (wr_a_q[wb] !== AW'(0) || wr_d_q[wb] !== a) begin errs++; $display("FAIL alu_opa: got %h=%h expected 0=%h", wr_a_q[wb], wr_d_q[wb], a); end
        vecs++; if (wr_a_q[wb+1] !== AW'(1) || wr_d_q[wb+1] !== b) begin errs++; $display("FAIL alu_opb: got %h=%h expected 1=%h", wr_a_q[wb+1], wr_d_q[wb+1], b); end
      end else begin
        vecs++; if (wr_a_q.size() != wb) begin errs++; $display("FAIL alu_dd_nowr: got %0d writes expected 0", wr_a_q.size() - wb); end
      end
      vecs++; if (n_aluen != ab + 1) begin errs++; $display("FAIL alu_en_pulses: got %0d expected 1", n_aluen - ab); end
      vecs++; if (clken_bad != cb || bus.CLK_EN !== 1'b0) begin errs++; $display("FAIL clk_en: bad %0d now %b expected 0/0", clken_bad - cb, bus.CLK_EN); end
      vecs++; if (tx_q.size() != base + 2) begin errs++; $display("FAIL alu_tx_count: got %0d expected 2", tx_q.size() - base); end
      vecs++; if (tx_q[base] !== exp[DW-1:0] || tx_q[base+1] !== exp[2*DW-1:DW]) begin
        errs++; $display("FAIL alu_result: got %h,%h expected %h,%h", tx_q[base], tx_q[base+1], exp[DW-1:0], exp[2*DW-1:DW]);
      end
    end
  endtask

  task automatic test_burst();
    logic [AW-1:0] a; logic [AW-1:0] ea; logic [FW-1:0] f; logic [2*DW-1:0] exp;
    int n, base, rb, ab;
    int ns[3] = '{3, 10, 0};
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? AW'(15) : AW'($urandom_range(0, 2**AW-1));
      n = (ns[k] == 0) ? 1 : ns[k];
      base = tx_q.size(); rb = rd_a_q.size();
      busy_hold = (k != 2);
      send(8'hEE); send(DW'(a)); send(DW'(ns[k]));
      wait_cycles(100);
      if (k == 1) begin
        vecs++; if (rd_a_q.size() != rb + DEPTH) begin errs++; $display("FAIL burst_full_stall: got %0d reads expected %0d", rd_a_q.size() - rb, DEPTH); end
      end
      if (k == 0) begin
        vecs++; if (tx_q.size() != base) begin errs++; $display("FAIL burst_busy_hold: got %0d frames expected 0", tx_q.size() - base); end
      end
      busy_hold = 1'b0;
      wait_tx(base + n); wait_cycles(10);
      vecs++; if (rd_a_q.size() != rb + n || tx_q.size() != base + n) begin
        errs++; $display("FAIL burst_count: got %0d reads %0d frames expected %0d", rd_a_q.size() - rb, tx_q.size() - base, n);
      end
      for (int i = 0; i < n; i++) begin
        ea = AW'((int'(a) + i) % (2**AW));
        vecs++; if (rd_a_q[rb+i] !== ea || tx_q[base+i] !== mdl_regs[ea]) begin
          errs++; $display("FAIL burst_item%0d: got addr %h data %h expected %h %h", i, rd_a_q[rb+i], tx_q[base+i], ea, mdl_regs[ea]);
        end
      end
    end
    // ALU issue needs two free slots: seven buffered reads leave only one
    a = AW'($urandom_range(0, 2**AW-1)); f = FW'($urandom_range(0, 5));
    exp = alu_f(mdl_regs[0], mdl_regs[1], f);
    base = tx_q.size(); ab = n_aluen;
    busy_hold = 1'b1;
    send(8'hEE); send(DW'(a)); send(DW'(7));
    wait_cycles(60);
    send(8'hDD); send(DW'(f));
    wait_cycles(20);
    vecs++; if (n_aluen != ab) begin errs++; $display("FAIL alu_room_stall: got %0d ALU_EN expected 0", n_aluen - ab); end
    busy_hold = 1'b0;
    wait_tx(base + 9); wait_cycles(10);
    vecs++; if (n_aluen != ab + 1 || tx_q.size() != base + 9) begin errs++; $display("FAIL alu_room_resume: got %0d ALU_EN %0d frames expected 1 9", n_aluen - ab, tx_q.size() - base); end
    vecs++; if (tx_q[base+7] !== exp[DW-1:0] || tx_q[base+8] !== exp[2*DW-1:DW] || tx_q[base+6] !== mdl_regs[AW'(int'(a) + 6)]) begin
      errs++; $display("FAIL alu_room_order: got %h %h %h", tx_q[base+6], tx_q[base+7], tx_q[base+8]);
    end
  endtask

  task automatic test_errors();
    logic [7:0] op; logic [AW-1:0] a; logic [DW-1:0] d; int cb, ob, base, rb, wb, bnd;
    for (int k = 0; k < 3; k++) begin
      op = 8'h55;
      if (k > 0) begin
        op = 8'($urandom_range(0, 255));
        while (op inside {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE}) op = 8'($urandom_range(0, 255));
      end
      cb = n_cmderr; wb = wr_a_q.size();
      send(DW'(op));
      wait_cycles(3);
      vecs++; if (n_cmderr != cb + 1) begin errs++; $display("FAIL cmd_err_%h: got %0d pulses expected 1", op, n_cmderr - cb); end
      a = AW'($urandom_range(2, 2**AW-1)); d = DW'($urandom);
      send(8'hAA); send(DW'(a)); send(d); wait_cycles(4);
      mdl_regs[a] = d;
      vecs++; if (wr_a_q.size() != wb + 1 || wr_a_q[wb] !== a || wr_d_q[wb] !== d) begin
        errs++; $display("FAIL after_cmd_err_write: got %0d writes expected 1 at %h", wr_a_q.size() - wb, a);
      end
    end
    rd_delay = 6; ob = n_ovr; base = tx_q.size(); rb = rd_a_q.size(); wb = wr_a_q.size();
    a = AW'($urandom_range(0, 2**AW-1));
    send(8'hBB); send(DW'(a));
    bnd = 0;
    while (rd_a_q.size() == rb && bnd < 50) begin @(negedge CLK); bnd++; end
    send(8'hAA);
    wait_tx(base + 1); wait_cycles(8);
    rd_delay = 1;
    vecs++; if (n_ovr != ob + 1) begin errs++; $display("FAIL overrun_pulse: got %0d expected 1", n_ovr - ob); end
    vecs++; if (tx_q.size() != base + 1 || tx_q[base] !== mdl_regs[a]) begin errs++; $display("FAIL overrun_read: got %h expected %h", tx_q[base], mdl_regs[a]); end
    d = DW'($urandom);
    send(8'hAA); send(DW'(7)); send(d); wait_cycles(4);
    mdl_regs[7] = d;
    vecs++; if (wr_a_q.size() != wb + 1 || wr_d_q[wb] !== d) begin errs++; $display("FAIL overrun_discard: got %0d writes expected 1", wr_a_q.size() - wb); end
  endtask

  task automatic test_reset_mid_alu();
    logic [AW-1:0] a; int base, ab, bnd;
    base = tx_q.size(); ab = n_aluen;
    busy_hold = 1'b1;
    send(8'hBB); send(DW'(3));
    wait_cycles(10);
    alu_delay = 30;
    send(8'hDD); send(DW'(2));
    bnd = 0;
    while (n_aluen == ab && bnd < 50) begin @(negedge CLK); bnd++; end
    wait_cycles(2);
    vecs++; if (n_aluen != ab + 1 || bus.CLK_EN !== 1'b1) begin errs++; $display("FAIL pre_reset_alu: en %0d clk_en %b expected 1 1", n_aluen - ab, bus.CLK_EN); end
    RST = 1'b1;
    @(negedge CLK);
    vecs++; if (all_outs() !== '0) begin errs++; $display("FAIL mid_reset_outs: got %h expected 0", all_outs()); end
    RST = 1'b0; busy_hold = 1'b0;
    wait_cycles(50);
    alu_delay = 3;
    vecs++; if (tx_q.size() != base) begin errs++; $display("FAIL fifo_flushed: got %0d frames expected 0", tx_q.size() - base); end
    vecs++; if (bus.clk_div_en !== 1'b1) begin errs++; $display("FAIL clk_div_en_again: got %b expected 1", bus.clk_div_en); end
    a = AW'($urandom_range(0, 2**AW-1));
    send(8'hBB); send(DW'(a));
    wait_tx(base + 1); wait_cycles(8);
    vecs++; if (tx_q.size() != base + 1 || tx_q[base] !== mdl_regs[a]) begin errs++; $display("FAIL post_reset_read: got %h expected %h", tx_q[base], mdl_regs[a]); end
  endtask

  initial begin
    bus.RX_P_DATA = '0;
    bus.RX_D_VLD = 1'b0;
    for (int i = 0; i < 2**AW; i++) mdl_regs[i] = DW'(i * 37 + 11);
    test_reset();
    test_write();
    test_read();
    test_alu();
    test_burst();
    test_errors();
    test_reset_mid_alu();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
